// File: rtl/uart_cmd_parser.sv
// uart_cmd_parser
//   Turns the UART receive byte stream into DDR user-port commands. One
//   ASCII-hex line per command, case-insensitive:
//     {'w'|'r'} SP* addr SP+ value SP* '\r'? '\n'
//   A 'w' line issues a single-word write (value = write data). An 'r' line
//   issues a burst read (value = length minus one). '\r' is ignored while
//   parsing. A malformed line is discarded with a one-cycle err pulse. Bytes
//   that arrive while a command is pending are dropped with a one-cycle drop
//   pulse.
//
// Ports
//   clk, rstn        clock, asynchronous active-low reset
//   rx_valid/rx_data one-cycle byte strobe from the UART receiver
//   cmd_valid/ready  command handshake toward the DDR user port
//   cmd_wr           1 = write, 0 = read
//   cmd_addr         word address (low A_WIDTH bits of the hex field)
//   cmd_wdata        write data (0 for reads)
//   cmd_len          read length minus one (0 for writes)
//   err, drop        one-cycle event pulses
//   busy             parser is not idle
module uart_cmd_parser #(
  parameter int A_WIDTH = 32,
  parameter int D_WIDTH = 32,
  parameter int L_WIDTH = 8
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic               rx_valid,
  input  logic [7:0]         rx_data,
  output logic               cmd_valid,
  input  logic               cmd_ready,
  output logic               cmd_wr,
  output logic [A_WIDTH-1:0] cmd_addr,
  output logic [D_WIDTH-1:0] cmd_wdata,
  output logic [L_WIDTH-1:0] cmd_len,
  output logic               err,
  output logic               drop,
  output logic               busy
);

  typedef enum logic [2:0] {
    S_IDLE, S_ADDR, S_VAL, S_TAIL, S_SKIP, S_ISSUE
  } state_t;

  state_t             state, state_nxt;
  logic               op_wr;
  logic [A_WIDTH-1:0] addr_acc;
  logic [D_WIDTH-1:0] wdata_acc;
  logic [L_WIDTH-1:0] len_acc;
  // Only "zero digits vs. some digits" matters to the grammar, so the
  // digit counters saturate at one bit.
  logic               addr_cnt, val_cnt;

  logic               is_hex, is_sp, is_cr, is_lf, is_w, is_r;
  logic [3:0]         nibble;
  logic               start, addr_shift, val_shift, err_nxt, drop_nxt;

  // Byte classification.
  always_comb begin
    // NOTE: every signal written here gets a default first, so no path
    // through the case can leave a latch behind.
    is_hex = 1'b1;
    nibble = 4'd0;
    if (rx_data >= "0" && rx_data <= "9")      nibble = 4'(rx_data - "0");
    else if (rx_data >= "a" && rx_data <= "f") nibble = 4'(rx_data - "a" + 8'd10);
    else if (rx_data >= "A" && rx_data <= "F") nibble = 4'(rx_data - "A" + 8'd10);
    else                                       is_hex = 1'b0;
  end

  assign is_sp = (rx_data == 8'h20);
  assign is_cr = (rx_data == 8'h0d);
  assign is_lf = (rx_data == 8'h0a);
  assign is_w  = (rx_data == "w") || (rx_data == "W");
  assign is_r  = (rx_data == "r") || (rx_data == "R");

  // Next-state and per-byte control strobes.
  always_comb begin
    state_nxt  = state;
    start      = 1'b0;
    addr_shift = 1'b0;
    val_shift  = 1'b0;
    err_nxt    = 1'b0;
    drop_nxt   = 1'b0;
    case (state)
      S_IDLE: if (rx_valid) begin
        if (is_w || is_r) begin
          start     = 1'b1;
          state_nxt = S_ADDR;
        end else if (!(is_sp || is_cr || is_lf)) begin
          err_nxt   = 1'b1;
          state_nxt = S_SKIP;
        end
      end
      S_ADDR: if (rx_valid && !is_cr) begin
        if (is_hex) addr_shift = 1'b1;
        else if (is_sp) begin
          if (addr_cnt) state_nxt = S_VAL;
        end else begin
          err_nxt   = 1'b1;
          state_nxt = is_lf ? S_IDLE : S_SKIP;
        end
      end
      S_VAL: if (rx_valid && !is_cr) begin
        if (is_hex) val_shift = 1'b1;
        else if (is_sp) begin
          if (val_cnt) state_nxt = S_TAIL;
        end else if (is_lf) begin
          if (val_cnt) state_nxt = S_ISSUE;
          else begin
            err_nxt   = 1'b1;
            state_nxt = S_IDLE;
          end
        end else begin
          err_nxt   = 1'b1;
          state_nxt = S_SKIP;
        end
      end
      S_TAIL: if (rx_valid && !is_cr && !is_sp) begin
        if (is_lf) state_nxt = S_ISSUE;
        else begin
          err_nxt   = 1'b1;
          state_nxt = S_SKIP;
        end
      end
      S_SKIP: if (rx_valid && is_lf) state_nxt = S_IDLE;
      S_ISSUE: begin
        // No parsing while a command is pending, including the accept cycle.
        drop_nxt = rx_valid;
        if (cmd_valid && cmd_ready) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state     <= S_IDLE;
      op_wr     <= 1'b0;
      addr_acc  <= '0;
      wdata_acc <= '0;
      len_acc   <= '0;
      addr_cnt  <= 1'b0;
      val_cnt   <= 1'b0;
      cmd_valid <= 1'b0;
      err       <= 1'b0;
      drop      <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments throughout, so every register here
      // sees the pre-edge value of every other one regardless of order.
      state <= state_nxt;
      err   <= err_nxt;
      drop  <= drop_nxt;
      if (start) begin
        op_wr     <= is_w;
        addr_acc  <= '0;
        wdata_acc <= '0;
        len_acc   <= '0;
        addr_cnt  <= 1'b0;
        val_cnt   <= 1'b0;
      end
      // Shift in a nibble; leading digits beyond the field width fall off.
      if (addr_shift) begin
        addr_acc <= A_WIDTH'({addr_acc, nibble});
        addr_cnt <= 1'b1;
      end
      if (val_shift) begin
        if (op_wr) wdata_acc <= D_WIDTH'({wdata_acc, nibble});
        else       len_acc   <= L_WIDTH'({len_acc, nibble});
        val_cnt <= 1'b1;
      end
      // cmd_valid rises one cycle after entering ISSUE and falls only on
      // the handshake, together with the return to IDLE.
      if (cmd_valid && cmd_ready)           cmd_valid <= 1'b0;
      else if (state == S_ISSUE)            cmd_valid <= 1'b1;
    end
  end

  // The accumulators are frozen in ISSUE, which keeps the fields stable
  // while cmd_valid is high. Clearing on the opcode keeps the unused field
  // of each command type at zero.
  assign cmd_wr    = op_wr;
  assign cmd_addr  = addr_acc;
  assign cmd_wdata = wdata_acc;
  assign cmd_len   = len_acc;
  assign busy      = (state != S_IDLE);

endmodule

// File: tb/tb_uart_cmd_parser.sv
// Self-checking bench for uart_cmd_parser: a table of whole lines sent with
// cmd_ready held high, then hand-written sequences for back-pressure, drops,
// latency and reset aborts.
module tb_uart_cmd_parser;

  logic        clk = 1'b0;
  logic        rstn;
  logic        rx_valid;
  logic [7:0]  rx_data;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_wr;
  logic [31:0] cmd_addr;
  logic [31:0] cmd_wdata;
  logic [7:0]  cmd_len;
  logic        err;
  logic        drop;
  logic        busy;

  uart_cmd_parser #(.A_WIDTH(32), .D_WIDTH(32), .L_WIDTH(8)) dut (
    .clk(clk), .rstn(rstn), .rx_valid(rx_valid), .rx_data(rx_data),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_wr(cmd_wr),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_len(cmd_len),
    .err(err), .drop(drop), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_total = 0;
  int n_pass  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
    else n_pass++;
  endtask

  // Event monitor on the falling edge: counts pulse cycles and handshakes.
  int          n_cmd, n_err, n_drop;
  logic        cap_wr;
  logic [31:0] cap_addr, cap_wdata;
  logic [7:0]  cap_len;

  always @(negedge clk) begin
    if (err)  n_err++;
    if (drop) n_drop++;
    if (cmd_valid && cmd_ready) begin
      n_cmd++;
      cap_wr    = cmd_wr;
      cap_addr  = cmd_addr;
      cap_wdata = cmd_wdata;
      cap_len   = cmd_len;
    end
  end

  task automatic clear_counts();
    n_cmd = 0; n_err = 0; n_drop = 0;
    cap_wr = 1'b1; cap_addr = '1; cap_wdata = '1; cap_len = '1;
  endtask

  // Called #1 after a rising edge; returns #1 after the sampling edge.
  task automatic send_byte(input logic [7:0] b);
    rx_valid = 1'b1;
    rx_data  = b;
    @(posedge clk); #1;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
  endtask

  task automatic send_line(input string s);
    for (int i = 0; i < s.len(); i++) send_byte(s[i]);
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  typedef struct {
    string       line;
    int          exp_cmd;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [7:0]  len;
    int          exp_err;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input string line, input int exp_cmd, input logic wr,
                     input logic [31:0] addr, input logic [31:0] wdata,
                     input logic [7:0] len, input int exp_err);
    vec_t v;
    v.line = line; v.exp_cmd = exp_cmd; v.wr = wr; v.addr = addr;
    v.wdata = wdata; v.len = len; v.exp_err = exp_err;
    vecs.push_back(v);
  endtask

  logic        stable;
  logic [72:0] held;

  initial begin
    // Vectors: line, commands expected, wr, addr, wdata, len, err pulses.
    add("R 100  ff \015\n",          1, 1'b0, 32'h100,      32'h0,        8'hff, 0);
    add("x12 3\n",                   0, 1'b0, 32'h0,        32'h0,        8'h0,  1);
    add("w12\n",                     0, 1'b0, 32'h0,        32'h0,        8'h0,  1);
    add("w12 G\n",                   0, 1'b0, 32'h0,        32'h0,        8'h0,  1);
    add("w0 1\n",                    1, 1'b1, 32'h0,        32'h1,        8'h0,  0);
    add("w123456789 ABCDEF012\n",    1, 1'b1, 32'h23456789, 32'hbcdef012, 8'h0,  0);
    add("r  Ab 7\015\n",             1, 1'b0, 32'hab,       32'h0,        8'h7,  0);
    add("W5 \n",                     0, 1'b0, 32'h0,        32'h0,        8'h0,  1);
    add("w1 2 x\n",                  0, 1'b0, 32'h0,        32'h0,        8'h0,  1);
    add("r3 1FF\n",                  1, 1'b0, 32'h3,        32'h0,        8'hff, 0);

    rstn = 1'b0; rx_valid = 1'b0; rx_data = 8'h00; cmd_ready = 1'b0;
    clear_counts();
    repeat (3) @(posedge clk);
    #1;
    check("reset_flags", {cmd_valid, cmd_wr, err, drop, busy}, 5'b0);
    check("reset_fields", {cmd_addr, cmd_wdata, cmd_len}, 72'h0);
    rstn = 1'b1;
    cycles(1);

    // Table: each line with cmd_ready tied high.
    cmd_ready = 1'b1;
    foreach (vecs[k]) begin
      clear_counts();
      send_line(vecs[k].line);
      cycles(4);
      check($sformatf("v%0d_ncmd", k), n_cmd, vecs[k].exp_cmd);
      check($sformatf("v%0d_nerr", k), n_err, vecs[k].exp_err);
      check($sformatf("v%0d_ndrop", k), n_drop, 0);
      check($sformatf("v%0d_busy", k), busy, 1'b0);
      if (vecs[k].exp_cmd == 1)
        check($sformatf("v%0d_fields", k), {cap_wr, cap_addr, cap_wdata, cap_len},
              {vecs[k].wr, vecs[k].addr, vecs[k].wdata, vecs[k].len});
    end

    // Latency and back-pressure: "w1A 5\n" held for 10 cycles.
    cmd_ready = 1'b0;
    clear_counts();
    send_line("w1A 5\n");
    check("lat_busy_in_issue", {busy, cmd_valid}, 2'b10);
    cycles(1);
    check("lat_valid", cmd_valid, 1'b1);
    check("lat_fields", {cmd_wr, cmd_addr, cmd_wdata, cmd_len}, {1'b1, 32'h1a, 32'h5, 8'h0});
    held   = {cmd_wr, cmd_addr, cmd_wdata, cmd_len};
    stable = 1'b1;
    for (int i = 0; i < 10; i++) begin
      cycles(1);
      if (!cmd_valid || {cmd_wr, cmd_addr, cmd_wdata, cmd_len} !== held) stable = 1'b0;
    end
    check("hold_stable", stable, 1'b1);
    cmd_ready = 1'b1;
    cycles(1);
    cmd_ready = 1'b0;
    check("accept_idle", {cmd_valid, busy}, 2'b00);
    check("accept_ncmd", n_cmd, 1);

    // Drops: second line arrives while the first command is pending.
    clear_counts();
    send_line("w1 2\n");
    send_line("w3 4\n");
    cycles(3);
    check("drop_count", n_drop, 5);
    check("drop_no_err", n_err, 0);
    check("drop_held", {cmd_valid, cmd_addr, cmd_wdata}, {1'b1, 32'h1, 32'h2});
    cmd_ready = 1'b1;
    cycles(1);
    cmd_ready = 1'b0;
    cycles(5);
    check("drop_one_cmd", n_cmd, 1);
    check("drop_first_fields", {cap_addr, cap_wdata}, {32'h1, 32'h2});
    check("drop_idle", {cmd_valid, busy}, 2'b00);

    // Reset in the middle of ADDR.
    clear_counts();
    send_line("w12");
    check("rst_addr_busy", busy, 1'b1);
    rstn = 1'b0;
    #1;
    check("rst_addr_flags", {cmd_valid, cmd_wr, err, drop, busy}, 5'b0);
    check("rst_addr_fields", {cmd_addr, cmd_wdata, cmd_len}, 72'h0);
    cycles(1);
    rstn = 1'b1;
    cycles(1);

    // Reset while a command is pending.
    send_line("w5 6\n");
    cycles(2);
    check("rst_issue_pending", cmd_valid, 1'b1);
    rstn = 1'b0;
    #1;
    check("rst_issue_flags", {cmd_valid, cmd_wr, err, drop, busy}, 5'b0);
    check("rst_issue_fields", {cmd_addr, cmd_wdata, cmd_len}, 72'h0);
    cycles(1);
    rstn = 1'b1;
    cycles(1);

    clear_counts();
    cmd_ready = 1'b1;
    send_line("r0 0\n");
    cycles(4);
    check("post_rst_ncmd", n_cmd, 1);
    check("post_rst_fields", {cap_wr, cap_addr, cap_len}, {1'b0, 32'h0, 8'h0});
    check("post_rst_nerr", n_err, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/uart_cmd_parser.md
Name: uart_cmd_parser

Overview:
- Command sequencer between the UART receiver byte stream (rx_valid/rx_data) and the DDR read/write user port.
- Parses ASCII-hex command lines and issues one command per line on a valid/ready interface.
- Write line: one word write. Read line: burst read.
- Response and TX formatting live in a separate block.

Parameters:
A_WIDTH, 32, address width of cmd_addr in bits (hex value truncated to low A_WIDTH bits)
D_WIDTH, 32, write data width of cmd_wdata in bits (low bits kept)
L_WIDTH, 8, width of cmd_len; read burst length minus one

Ports:
clk  input  1  clock
rstn  input  1  asynchronous, active-low reset
rx_valid  input  1  one-cycle strobe, rx_data valid
rx_data  input  8  received byte
cmd_valid  output  1  command pending
cmd_ready  input  1  downstream accepts command
cmd_wr  output  1  1 = write, 0 = read
cmd_addr  output  A_WIDTH  word address
cmd_wdata  output  D_WIDTH  write data (0 for reads)
cmd_len  output  L_WIDTH  read length minus one (0 for writes)
err  output  1  one-cycle pulse: malformed line discarded
drop  output  1  one-cycle pulse: byte lost while command pending
busy  output  1  high in any state except IDLE

Behaviour:
- Reset values: all outputs 0; state IDLE; internal accumulators and digit counters 0. Reset mid-line or mid-handshake aborts the line with no command issued.
- Grammar, case-insensitive: {'w'|'r'} addr SP+ value SP* '\r'? '\n'.
  - addr and value are 1 or more hex digits.
  - Spaces between opcode and addr are allowed.
  - '\r' is ignored everywhere.
- Hex accumulate: acc <= (acc << 4) | nibble, truncated to field width. Excess leading digits are silently truncated, not an error.
- States and transitions, evaluated only on rx_valid:
  - IDLE:
    - 'w'/'W' or 'r'/'R': latch op, clear accumulators, go ADDR.
    - SP, '\r', '\n': stay.
    - Other byte: err pulse, go SKIP.
  - ADDR:
    - Hex digit: accumulate, addr_cnt++.
    - SP: if addr_cnt = 0 stay, else go VAL.
    - Any other byte, including '\n': err pulse, go SKIP (or IDLE if the byte is '\n').
  - VAL:
    - Hex digit: accumulate into wdata (write) or len (read), val_cnt++.
    - SP with val_cnt > 0: go TAIL. SP with val_cnt = 0: stay.
    - '\n' with val_cnt > 0: go ISSUE.
    - '\n' with val_cnt = 0: err pulse, go IDLE.
    - Other byte: err pulse, go SKIP.
  - TAIL:
    - SP: stay.
    - '\n': go ISSUE.
    - Other byte: err pulse, go SKIP.
  - SKIP: discard bytes until '\n', then go IDLE. No further err pulses in SKIP.
  - ISSUE:
    - cmd_valid = 1; cmd_* fields stable while cmd_valid is high.
    - On cmd_valid & cmd_ready: next cycle cmd_valid = 0, state IDLE.
    - Any rx_valid while in ISSUE, including the handshake cycle: byte dropped, drop pulse, no parse.
- Latency: the '\n' byte sampled at edge N gives cmd_valid = 1 after edge N+1 (registered). Zero-wait accept if cmd_ready is already high.
- cmd_valid never deasserts without cmd_ready. Fields never change while valid.
- Write command: cmd_len = 0. Read command: cmd_wdata = 0.
- err and drop never assert in the same cycle; each is a single-cycle pulse per event.
- The parser itself places no limit on back-to-back rx_valid; every cycle may carry a byte.

Test Plan:
- "w1A 5\n": after '\n', cmd_valid = 1 next cycle with cmd_wr = 1, cmd_addr = 0x1A, cmd_wdata = 0x5, cmd_len = 0. Hold cmd_ready = 0 for 10 cycles: fields stable; then ready for 1 cycle: cmd_valid = 0, busy = 0.
- "R 100  ff \r\n" with cmd_ready tied 1: one command with cmd_wr = 0, addr = 0x100, len = 0xFF; single-cycle cmd_valid; no err.
- Malformed lines:
  - "x12 3\n" gives one err pulse and no command.
  - "w12\n" gives one err pulse and no command.
  - "w12 G\n" gives one err pulse and no command.
  - A following "w0 1\n" parses correctly.
- Truncation: "w123456789 ABCDEF012\n" gives cmd_addr = 0x23456789, cmd_wdata = 0xBCDEF012 (32-bit params).
- With cmd_ready = 0, send "w1 2\n" then "w3 4\n": first command held; 5 drop pulses; after ready, no second command issued and parser back in IDLE.
- Assert rstn low during ADDR and again during ISSUE: all outputs 0 immediately. After release, "r0 0\n" yields addr = 0, len = 0.
